quantize_servo: RTL and testbench
=================================

// Module: quantize_servo
// PURPOSE
//  Closed-loop controller for the 2-bit dithered quantizer. Generates its 10-bit dither
//  word and servos its signed 8-bit offset so positive/negative codes balance (DC removal).
//  Counts quantizer outputs over fixed windows; adjusts offset once per window.
//  Reports per-window statistics for a later AGC stage. One instance per quantizer channel.
// PARAMETERS
//  WIN_LOG2   10      window = 2**WIN_LOG2 valid samples
//  DEADBAND   16      allowed |pos_count - 2**(WIN_LOG2-1)| with no correction
//  STEP       1       offset change per corrective window (LSBs, 1..16)
//  LOCK_N     4       consecutive uncorrected windows before lock asserts
//  LFSR_SEED  10'h3FF dither LFSR reset value (must be nonzero)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous reset, active high
//  en           in   1   servo enable; 0 = hold offset, no windows run
//  y            in   2   quantizer code: 11 +large, 10 +small, 01 -small, 00 -large
//  y_valid      in   1   y carries a sample this cycle
//  cfg_we       in   1   one-cycle strobe: load cfg_offset into offset
//  cfg_offset   in   8   signed manual offset value
//  offset       out  8   signed offset to quantizer (registered)
//  random       out  10  dither word to quantizer (LFSR state)
//  win_done     out  1   one-cycle pulse; stats below updated this cycle
//  pos_count    out  WIN_LOG2+1  count of y[1]==1 in last completed window
//  mag_count    out  WIN_LOG2+1  count of large codes (y[1]==y[0]) in last window
//  lock         out  1   offset stable for LOCK_N windows
// BEHAVIOUR
//  Reset: offset=0, random=LFSR_SEED, win_done=0, pos_count=0, mag_count=0, lock=0,
//   state=IDLE, internal counters=0.
//  Dither LFSR: Fibonacci, x^10+x^7+1, shifts every cycle incl. IDLE; never held by en.
//   next = {lfsr[8:0], lfsr[9]^lfsr[6]}. Period 1023.
//  States: IDLE, ACCUM, UPDATE.
//   IDLE: counters cleared. en=1 -> ACCUM next cycle.
//   ACCUM: each y_valid cycle: smp_cnt++, pos_acc += y[1], mag_acc += (y[1]==y[0]).
//     y_valid with smp_cnt == 2**WIN_LOG2-1 counts that sample, -> UPDATE.
//     en=0 -> IDLE; partial window discarded, offset/stats/lock hold.
//   UPDATE (1 cycle): d = pos_acc - 2**(WIN_LOG2-1) (signed, WIN_LOG2+2 bits).
//     d > DEADBAND: offset -= STEP; d < -DEADBAND: offset += STEP; else unchanged.
//     Offset saturates at -128/+127 (no wrap). Saturated step still counts as correction.
//     pos_count/mag_count <= accumulators; win_done=1; accumulators cleared.
//     Correction: lock=0, stable_cnt=0. None: stable_cnt++ (sat at LOCK_N);
//     lock=1 once stable_cnt reaches LOCK_N.
//     -> ACCUM if en else IDLE. y_valid during UPDATE is dropped (not counted).
//  Offset update latency: visible on offset output the cycle after UPDATE.
//  cfg_we: in any state, offset <= cfg_offset next cycle; has priority over a
//   same-cycle UPDATE adjustment (stats/win_done still issue); current window
//   accumulators cleared, lock=0, stable_cnt=0; state continues (ACCUM restarts window).
//  Reset mid-window: all state returns to reset values next cycle; no win_done.
//  Counter widths WIN_LOG2+1 so full-window count 2**WIN_LOG2 is representable.
// TESTING
//  1. Reset, en=1, 1024 samples y=10 (all +) -> win_done at UPDATE, pos_count=1024,
//     mag_count=0, offset=-1 (8'hFF) next cycle, lock=0.
//  2. Alternating y=11/00 for 4 windows -> pos_count=512, mag_count=1024 each,
//     offset unchanged, lock=1 after 4th win_done.
//  3. cfg_offset=8'h7F, then all-negative windows -> offset stays 8'h7F (saturates), lock=0.
//  4. pos_count=528 (d=+16) -> no change; 529 -> offset -1; 495 (d=-17) -> +1.
//  5. cfg_we same cycle as UPDATE with cfg_offset=8'h10 -> offset=8'h10, win_done=1,
//     next window needs full 1024 samples.
//  6. en=0 at sample 500, en=1 later -> no win_done until 1024 new samples; random
//     matches reference LFSR model every cycle from reset.

Source files
------------

// File: rtl/quantize_servo_if.sv
// ============================================================================
// quantize_servo_if : control/status bundle between quantizer servo and user
// Rev 1.0
// ============================================================================
`default_nettype none

interface quantize_servo_if #(
  parameter int WIN_LOG2 = 10
);
  logic                en;
  logic [1:0]          y;
  logic                y_valid;
  logic                cfg_we;
  logic [7:0]          cfg_offset;
  logic [7:0]          offset;
  logic [9:0]          random;
  logic                win_done;
  logic [WIN_LOG2:0]   pos_count;
  logic [WIN_LOG2:0]   mag_count;
  logic                lock;

  modport master (
    output en, y, y_valid, cfg_we, cfg_offset,
    input  offset, random, win_done, pos_count, mag_count, lock
  );

  modport slave (
    input  en, y, y_valid, cfg_we, cfg_offset,
    output offset, random, win_done, pos_count, mag_count, lock
  );
endinterface

`default_nettype wire

// File: rtl/quantize_servo.sv
// ============================================================================
// quantize_servo : dither LFSR plus windowed DC-offset servo for 2-bit quantizer
// Rev 1.0
// ============================================================================
`default_nettype none

module quantize_servo #(
  parameter int         WIN_LOG2  = 10,
  parameter int         DEADBAND  = 16,
  parameter int         STEP      = 1,
  parameter int         LOCK_N    = 4,
  parameter logic [9:0] LFSR_SEED = 10'h3FF
) (
  input  wire logic          clk,
  input  wire logic          reset,
  quantize_servo_if.slave    bus
);

  localparam int c_CW = WIN_LOG2 + 1;
  localparam int c_DW = WIN_LOG2 + 2;
  localparam int c_SW = $clog2(LOCK_N + 1);
  localparam logic signed [c_DW-1:0] c_HALF = c_DW'(2 ** (WIN_LOG2 - 1));
  localparam logic signed [c_DW-1:0] c_DB   = c_DW'(DEADBAND);
  localparam logic signed [8:0]      c_STEP = 9'(STEP);
  localparam logic [c_SW-1:0]        c_LOCK = c_SW'(LOCK_N);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [9:0]          r_lfsr;
  logic [WIN_LOG2-1:0] r_smp_cnt;
  logic [c_CW-1:0]     r_pos_acc, r_mag_acc;
  logic [c_CW-1:0]     r_pos_count, r_mag_count;
  logic [7:0]          r_offset;
  logic [c_SW-1:0]     r_stable;
  logic                r_lock, r_win_done;

  logic                w_count, w_update, w_clear;
  logic signed [c_DW-1:0] w_d;
  logic                w_dec, w_inc, w_corr;
  logic signed [8:0]   w_off_wide, w_off_dec, w_off_inc;
  logic [7:0]          w_off_next;
  logic [c_SW-1:0]     w_stable_inc;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // A cfg write in ACCUM restarts the window, so it also blocks the move to UPDATE.
  always_comb begin
    w_next   = r_state;
    w_count  = 1'b0;
    w_update = 1'b0;
    w_clear  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clear = 1'b1;
        if (bus.en) w_next = S_ACCUM;
      end
      S_ACCUM: begin
        if (!bus.en) begin
          w_next = S_IDLE;
        end else if (!bus.cfg_we && bus.y_valid) begin
          w_count = 1'b1;
          if (r_smp_cnt == {WIN_LOG2{1'b1}}) w_next = S_UPDATE;
        end
      end
      S_UPDATE: begin
        w_update = 1'b1;
        w_next   = bus.en ? S_ACCUM : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_d        = $signed({1'b0, r_pos_acc}) - c_HALF;
    w_dec      = (w_d > c_DB);
    w_inc      = (w_d < -c_DB);
    w_corr     = w_dec | w_inc;
    w_off_wide = {r_offset[7], r_offset};
    w_off_dec  = w_off_wide - c_STEP;
    w_off_inc  = w_off_wide + c_STEP;
    w_off_next = r_offset;
    if (w_dec)      w_off_next = (w_off_dec < -9'sd128) ? 8'h80 : w_off_dec[7:0];
    else if (w_inc) w_off_next = (w_off_inc > 9'sd127)  ? 8'h7F : w_off_inc[7:0];
    w_stable_inc = (r_stable == c_LOCK) ? r_stable : r_stable + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr      <= LFSR_SEED;
      r_smp_cnt   <= '0;
      r_pos_acc   <= '0;
      r_mag_acc   <= '0;
      r_pos_count <= '0;
      r_mag_count <= '0;
      r_offset    <= '0;
      r_stable    <= '0;
      r_lock      <= 1'b0;
      r_win_done  <= 1'b0;
    end else begin
      r_lfsr     <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
      r_win_done <= w_update;
      if (w_update) begin
        r_pos_count <= r_pos_acc;
        r_mag_count <= r_mag_acc;
      end
      if (w_clear || w_update || bus.cfg_we) begin
        r_smp_cnt <= '0;
        r_pos_acc <= '0;
        r_mag_acc <= '0;
      end else if (w_count) begin
        r_smp_cnt <= r_smp_cnt + 1'b1;
        r_pos_acc <= r_pos_acc + c_CW'(bus.y[1]);
        r_mag_acc <= r_mag_acc + c_CW'(bus.y[1] == bus.y[0]);
      end
      if (bus.cfg_we)            r_offset <= bus.cfg_offset;
      else if (w_update && w_corr) r_offset <= w_off_next;
      if (bus.cfg_we) begin
        r_stable <= '0;
        r_lock   <= 1'b0;
      end else if (w_update) begin
        if (w_corr) begin
          r_stable <= '0;
          r_lock   <= 1'b0;
        end else begin
          r_stable <= w_stable_inc;
          r_lock   <= (w_stable_inc == c_LOCK);
        end
      end
    end
  end

  assign bus.offset    = r_offset;
  assign bus.random    = r_lfsr;
  assign bus.win_done  = r_win_done;
  assign bus.pos_count = r_pos_count;
  assign bus.mag_count = r_mag_count;
  assign bus.lock      = r_lock;

endmodule

`default_nettype wire

// File: tb/tb_quantize_servo.sv
// ============================================================================
// tb_quantize_servo : directed window vectors plus hand sequences for the servo
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_quantize_servo;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  quantize_servo_if #(.WIN_LOG2(10)) bus();

  quantize_servo #(
    .WIN_LOG2(10), .DEADBAND(16), .STEP(1), .LOCK_N(4), .LFSR_SEED(10'h3FF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int early = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference dither LFSR, compared every cycle once reset has been seen.
  logic [9:0] m_lfsr;
  logic       m_live = 1'b0;
  int         lfsr_bad = 0;
  always @(posedge clk) begin
    if (reset) begin
      m_lfsr <= 10'h3FF;
      m_live <= 1'b1;
    end else begin
      m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end
  end
  always @(negedge clk) begin
    if (m_live && (bus.random !== m_lfsr)) lfsr_bad++;
  end

  // mode 0: first npos samples positive, first nmag samples large; mode 1: 11/00 alternating
  task automatic drive(input int n, input int mode, input int npos, input int nmag);
    logic p, l;
    for (int i = 0; i < n; i++) begin
      if (mode == 1) begin
        p = (i % 2 == 0);
        l = 1'b1;
      end else begin
        p = (i < npos);
        l = (i < nmag);
      end
      bus.y_valid = 1'b1;
      bus.y       = {p, l ? p : ~p};
      @(negedge clk);
      if (bus.win_done) early++;
    end
    bus.y_valid = 1'b0;
  endtask

  task automatic idle_watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.win_done) early++;
    end
  endtask

  task automatic expect_done(input string name, input int ep, input int em,
                             input logic [7:0] eo, input logic el);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(negedge clk);
      if (bus.win_done) found = 1'b1;
    end
    chk({name, ".done"},  32'(found), 32'd1);
    chk({name, ".early"}, early, 0);
    early = 0;
    chk({name, ".pos"},  32'(bus.pos_count), ep);
    chk({name, ".mag"},  32'(bus.mag_count), em);
    chk({name, ".off"},  32'(bus.offset), 32'(eo));
    chk({name, ".lock"}, 32'(bus.lock), 32'(el));
  endtask

  typedef struct {
    int         mode;
    int         npos;
    int         nmag;
    logic       cfg;
    logic [7:0] cfgv;
    int         ep;
    int         em;
    logic [7:0] eo;
    logic       el;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{0, 1024,    0, 1'b0, 8'h00, 1024,    0, 8'hFF, 1'b0};
    vt[1]  = '{1,    0,    0, 1'b0, 8'h00,  512, 1024, 8'hFF, 1'b0};
    vt[2]  = '{1,    0,    0, 1'b0, 8'h00,  512, 1024, 8'hFF, 1'b0};
    vt[3]  = '{1,    0,    0, 1'b0, 8'h00,  512, 1024, 8'hFF, 1'b0};
    vt[4]  = '{1,    0,    0, 1'b0, 8'h00,  512, 1024, 8'hFF, 1'b1};
    vt[5]  = '{0,  528,    0, 1'b0, 8'h00,  528,    0, 8'hFF, 1'b1};
    vt[6]  = '{0,  529,    0, 1'b0, 8'h00,  529,    0, 8'hFE, 1'b0};
    vt[7]  = '{0,  495,    0, 1'b0, 8'h00,  495,    0, 8'hFF, 1'b0};
    vt[8]  = '{0,  496,    0, 1'b0, 8'h00,  496,    0, 8'hFF, 1'b0};
    vt[9]  = '{0,    0, 1024, 1'b1, 8'h7F,    0, 1024, 8'h7F, 1'b0};
    vt[10] = '{0,    0,    0, 1'b0, 8'h00,    0,    0, 8'h7F, 1'b0};
    vt[11] = '{0, 1024, 1024, 1'b1, 8'h80, 1024, 1024, 8'h80, 1'b0};

    reset          = 1'b1;
    bus.en         = 1'b0;
    bus.y          = 2'b00;
    bus.y_valid    = 1'b0;
    bus.cfg_we     = 1'b0;
    bus.cfg_offset = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst.off",  32'(bus.offset),    0);
    chk("rst.rnd",  32'(bus.random),    32'h3FF);
    chk("rst.done", 32'(bus.win_done),  0);
    chk("rst.pos",  32'(bus.pos_count), 0);
    chk("rst.mag",  32'(bus.mag_count), 0);
    chk("rst.lock", 32'(bus.lock),      0);

    reset  = 1'b0;
    bus.en = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      if (vt[v].cfg) begin
        bus.cfg_we     = 1'b1;
        bus.cfg_offset = vt[v].cfgv;
        @(negedge clk);
        bus.cfg_we = 1'b0;
        chk($sformatf("v%0d.cfg", v), 32'(bus.offset), 32'(vt[v].cfgv));
      end
      drive(1024, vt[v].mode, vt[v].npos, vt[v].nmag);
      expect_done($sformatf("v%0d", v), vt[v].ep, vt[v].em, vt[v].eo, vt[v].el);
    end

    // cfg write coincident with UPDATE
    drive(1024, 1, 0, 0);
    bus.cfg_we     = 1'b1;
    bus.cfg_offset = 8'h10;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    chk("t5.done", 32'(bus.win_done),  1);
    chk("t5.pos",  32'(bus.pos_count), 512);
    chk("t5.off",  32'(bus.offset),    32'h10);
    @(negedge clk);
    chk("t5.pulse", 32'(bus.win_done), 0);
    drive(1023, 1, 0, 0);
    idle_watch(4);
    drive(1, 1, 0, 0);
    expect_done("t5b", 513, 1024, 8'h10, 1'b0);

    // en drop mid-window discards the partial window
    drive(500, 0, 500, 0);
    bus.en      = 1'b0;
    bus.y_valid = 1'b1;
    bus.y       = 2'b10;
    idle_watch(5);
    chk("t6.hold", 32'(bus.offset), 32'h10);
    bus.en      = 1'b1;
    bus.y_valid = 1'b0;
    @(negedge clk);
    drive(1023, 0, 0, 1024);
    idle_watch(3);
    drive(1, 0, 0, 1024);
    expect_done("t6", 0, 1024, 8'h11, 1'b0);

    // reset mid-window
    drive(600, 0, 600, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t7.off",  32'(bus.offset),    0);
    chk("t7.pos",  32'(bus.pos_count), 0);
    chk("t7.mag",  32'(bus.mag_count), 0);
    chk("t7.done", 32'(bus.win_done),  0);
    chk("t7.rnd",  32'(bus.random),    32'h3FF);
    reset = 1'b0;
    @(negedge clk);
    drive(424, 0, 424, 0);
    idle_watch(4);
    drive(600, 0, 600, 0);
    expect_done("t7b", 1024, 0, 8'hFF, 1'b0);

    chk("lfsr.track", lfsr_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
